ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Single-port AHB-Lite slave wrapping an on-chip word-organised SRAM. It is the downstream stage of our AHB master and answers its NONSEQ read/write transfers with configurable wait states, byte-lane writes and a two-cycle ERROR response for illegal accesses. The slave sits on the bus behind the address decoder: `HSEL` comes from the decoder, and `HREADYOUT` is returned to the master as `HREADY` through the response mux.

## Interface
Parameters:
- MEM_WORDS, 1024: SRAM depth in 32-bit words; must be a power of two, 16..65536.
- WAIT_STATES, 1: `HREADYOUT`-low cycles per OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address. Bits [1:0] are the lane; bits [31:2] are the word index.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  32  write data, sampled in the data phase.
- HREADY  in  1  bus-level ready; gates address-phase acceptance.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  00 OKAY, 01 ERROR.
- HRDATA  out  32  read data.

## Operation
- **Address-phase accept**: accept a transfer on a rising edge when `HSEL & HTRANS[1] & HREADY` is true. At that edge, latch the word index, lane, `HSIZE` and `HWRITE`.
  - SEQ is treated exactly like NONSEQ; there is no burst-address checking.
  - IDLE and BUSY transfers, and unselected cycles, get a zero-wait OKAY.
- **Error classification** is done at the accept edge. Any of the following is an error:
  - `HSIZE` > 010;
  - a halfword with `HADDR[0]`=1;
  - a word with `HADDR[1:0]`≠00;
  - `HADDR[31:2]` ≥ MEM_WORDS.
- **States**:
  - IDLE: `HREADYOUT`=1, `HRESP`=00.
  - WAIT: `HREADYOUT`=0, `HRESP`=00. A 4-bit counter is loaded with WAIT_STATES and counts down.
  - DONE: `HREADYOUT`=1, `HRESP`=00.
  - ERR1: `HREADYOUT`=0, `HRESP`=01.
  - ERR2: `HREADYOUT`=1, `HRESP`=01.
- **Transitions on accept**:
  - error → ERR1;
  - legal with WAIT_STATES>0 → WAIT;
  - legal with WAIT_STATES=0 → DONE.
- **Other transitions**:
  - WAIT → DONE when the counter reaches 1.
  - ERR1 → ERR2 always.
  - From DONE or ERR2: go to the next accept target if a new transfer is accepted at that edge, else IDLE.
- **Read**: `HRDATA` is loaded with `mem[index]` on the edge entering DONE and held until the next DONE load. `HRDATA` is loaded with 0 on entering ERR1.
- **Write**: commits on the edge leaving DONE, using `HWDATA` with byte enables derived from lane and size (little-endian).
  - byte: lane `HADDR[1:0]`;
  - halfword: lanes {`HADDR[1]`,0} and {`HADDR[1]`,1};
  - word: all four lanes.
- **Forwarding**: a read accepted at the edge that commits a write to the same word must return the merged post-write word. This case only arises with WAIT_STATES=0.
- Erroring transfers never modify memory.

## Timing
- **Reset values**: `HREADYOUT`=1, `HRESP`=00, `HRDATA`=0, state IDLE, counter 0. SRAM contents are not reset.
- **Reset mid-transaction**: the transfer is aborted and a pending write is not committed. One cycle after `HRESET` is sampled high, outputs equal the reset values.
- **Latency from the accept edge**:
  - OKAY: `HREADYOUT` is low for exactly WAIT_STATES cycles, then high for one cycle with `HRDATA` valid.
  - ERROR: exactly one low cycle, then one high cycle, with `HRESP`=01 in both.
- Back-to-back accepts during DONE or ERR2 are supported with no idle bubble.
- `HREADYOUT` is never low outside WAIT or ERR1.

## Test plan
- **Word write/read, WAIT_STATES=1**: write 0xDEADBEEF to 0x10, then read 0x10. Each transfer shows 1 low cycle, then `HREADYOUT`=1 with `HRESP`=00. The read returns `HRDATA`=0xDEADBEEF.
- **Byte lane write**: preload 0x11223344 at 0x10, then byte-write 0x000000AA... with `HWDATA`=0x0000AA00 at 0x11. Reading 0x10 returns 0x1122AA44.
- **Out-of-range address**: NONSEQ to 4*MEM_WORDS produces cycle 1 `HREADYOUT`=0/`HRESP`=01, then cycle 2 `HREADYOUT`=1/`HRESP`=01, with `HRDATA`=0. Word 0 is unchanged.
- **Illegal size/alignment**: a word write to 0x02 produces an ERROR pair and memory is unchanged. `HSIZE`=011 also produces an ERROR pair.
- **Forwarding, WAIT_STATES=0**: write 0x00000055 to 0x20, immediately followed by a read of 0x20. The read's DONE cycle shows `HRDATA`=0x00000055, and there are no low `HREADYOUT` cycles.
- **Reset mid-transaction**: assert `HRESET` during WAIT of a write of 0x12345678 to 0x30. The next cycle shows `HREADYOUT`=1, `HRESP`=00, `HRDATA`=0. A later read of 0x30 returns the pre-write value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised on-chip SRAM.
// Accepts NONSEQ/SEQ transfers, inserts WAIT_STATES wait cycles before each
// OKAY data phase, supports byte/halfword/word writes with byte enables, and
// answers illegal accesses with a two-cycle ERROR response.
//
// Ports:
//   HCLK       bus clock, rising edge
//   HRESET     synchronous active-high reset
//   HSEL       slave select from the address decoder
//   HADDR      byte address ([1:0] lane, [31:2] word index)
//   HTRANS     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     1 = write
//   HSIZE      000 byte, 001 halfword, 010 word
//   HWDATA     write data (data phase)
//   HREADY     bus-level ready, gates address-phase acceptance
//   HREADYOUT  slave ready
//   HRESP      00 OKAY, 01 ERROR
//   HRDATA     read data
//
// state | meaning
// IDLE  | no data phase in progress
// WAIT  | OKAY data phase, inserting wait cycles
// DONE  | OKAY data phase, final cycle (read data valid / write commits)
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ahb_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lane_q, lane_d;
    logic [2:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [MEM_WORDS];

    logic          take;
    logic          addr_err;
    state_t        target;
    logic          wr_en;
    logic [3:0]    be;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          unused_trans0;

    assign unused_trans0 = HTRANS[0];

    // A new address phase is only taken when no data phase is stalling the bus.
    assign take = HSEL & HTRANS[1] & HREADY &
                  ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR2));

    assign addr_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                    | (|HADDR[31:AW+2]);

    assign target = addr_err ? S_ERR1 : ((WAIT_STATES == 0) ? S_DONE : S_WAIT);

    // Writes commit on the edge that leaves DONE; a reset on that edge aborts it.
    assign wr_en = (state_q == S_DONE) & write_q & ~HRESET;

    always_comb begin
        be = 4'b1111;
        case (size_q)
            3'd0:    be = 4'b0001 << lane_q;
            3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // In WAIT the transfer is already latched; otherwise DONE is entered
    // straight from the address phase, so read the live address.
    assign rd_idx = (state_q == S_WAIT) ? idx_q : HADDR[AW+1:2];

    always_comb begin
        rd_word = mem[rd_idx];
        // Read accepted on the edge that commits a write to the same word.
        if (wr_en && (idx_q == rd_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        rdata_d = rdata_q;

        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_DONE;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            state_d = target;
            cnt_d   = 4'(WAIT_STATES);
            idx_d   = HADDR[AW+1:2];
            lane_d  = HADDR[1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
        end

        if ((state_d == S_DONE) && (take || (state_q == S_WAIT))) begin
            rdata_d = rd_word;
        end else if (state_d == S_ERR1) begin
            rdata_d = 32'h0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= 3'b000;
            write_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HREADYOUT = ~((state_q == S_WAIT) | (state_q == S_ERR1));
    assign HRESP     = ((state_q == S_ERR1) | (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (one wait state / zero wait states)
// driven by a pipelined AHB master task and checked against a word-array model.
module tb_ahb_sram_slave;

    localparam int MW = 1024;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic [1:0]  hresp     [2];
    logic [31:0] hrdata    [2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mdl   [2][64];
    bit          known [2][64];
    xfer_t       q[$];

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(1)) dut_ws1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
        .HWDATA(hwdata[0]), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut_ws0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
        .HWDATA(hwdata[1]), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic bit is_err(input xfer_t x);
        return (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
               (x.size == 3'd2 && x.addr[1:0] != 2'b00) || ((x.addr >> 2) >= MW);
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.size = size;
        x.addr = addr; x.wdata = wdata;
        return x;
    endfunction

    task automatic drive(input int d, input xfer_t x);
        hsel[d]   = x.sel;
        htrans[d] = x.trans;
        hwrite[d] = x.wr;
        hsize[d]  = x.size;
        haddr[d]  = x.addr;
    endtask

    task automatic drive_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
        hsize[d] = 3'b000; haddr[d] = 32'h0;
    endtask

    task automatic model_write(input int d, input xfer_t x);
        int w;
        w = int'(x.addr >> 2);
        for (int b = 0; b < 4; b++) begin
            bit en;
            if (x.size == 3'd0)      en = (b == int'(x.addr[1:0]));
            else if (x.size == 3'd1) en = ((b / 2) == int'(x.addr[1]));
            else                     en = 1'b1;
            if (en) mdl[d][w][8*b +: 8] = x.wdata[8*b +: 8];
        end
        if (x.size == 3'd2) known[d][w] = 1'b1;
    endtask

    task automatic complete(input int d, input xfer_t x, input int low);
        bit e;
        int w;
        e = is_err(x);
        w = int'(x.addr >> 2);
        check_eq("low_cycles", low, e ? 1 : ws(d));
        check_eq("final_resp", 32'(hresp[d]), e ? 32'h1 : 32'h0);
        if (e) begin
            check_eq("err_rdata", hrdata[d], 32'h0);
        end else if (!x.wr) begin
            if (known[d][w]) check_eq("rdata", hrdata[d], mdl[d][w]);
        end else begin
            model_write(d, x);
        end
    endtask

    task automatic run_queue(input int d);
        xfer_t dp;
        bit    dp_v;
        bit    rdy;
        int    low;
        int    guard;
        dp_v = 1'b0; low = 0; guard = 0;
        while ((q.size() > 0 || dp_v) && guard < 4000) begin
            @(negedge clk);
            guard++;
            rdy = hreadyout[d];
            if (dp_v) begin
                hwdata[d] = dp.wdata;
                if (!rdy) begin
                    low++;
                    check_eq("low_resp", 32'(hresp[d]), is_err(dp) ? 32'h1 : 32'h0);
                    if (low > 20) begin
                        check_eq("wait_bound", low, is_err(dp) ? 1 : ws(d));
                        dp_v = 1'b0;
                    end
                end else begin
                    complete(d, dp, low);
                    dp_v = 1'b0;
                end
            end else begin
                check_eq("idle_ready", 32'(rdy), 32'h1);
                check_eq("idle_resp", 32'(hresp[d]), 32'h0);
            end
            if (rdy && q.size() > 0) begin
                xfer_t x;
                x = q.pop_front();
                drive(d, x);
                if (x.sel && x.trans[1]) begin
                    dp = x; dp_v = 1'b1; low = 0;
                end
            end else begin
                drive_idle(d);
            end
        end
        check_eq("queue_drained", q.size(), 0);
        q.delete();
    endtask

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int r;
        r = $urandom_range(0, 99);
        x.wr = 1'($urandom); x.wdata = $urandom; x.sel = 1'b1;
        x.trans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        x.size = 3'(2'($urandom_range(0, 2)));
        if (r < 12) begin
            if ($urandom_range(0, 1) == 0) x.sel = 1'b0;
            else x.trans = 2'($urandom_range(0, 1));
            x.addr = 32'($urandom_range(0, 63));
        end else if (r < 26) begin
            case ($urandom_range(0, 3))
                0: begin x.size = 3'($urandom_range(3, 7)); x.addr = 32'($urandom_range(0, 63)); end
                1: begin x.size = 3'd1; x.addr = 32'($urandom_range(0, 15) * 4 + 1 + 2 * $urandom_range(0, 1)); end
                2: begin x.size = 3'd2; x.addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)); end
                default: begin x.size = 3'd2; x.addr = 32'(MW * 4) + ($urandom & 32'h7FFF_FFFC); end
            endcase
        end else begin
            logic [1:0] lane;
            lane = 2'($urandom_range(0, 3));
            if (x.size == 3'd1) lane[0] = 1'b0;
            if (x.size == 3'd2) lane = 2'b00;
            x.addr = 32'($urandom_range(0, 15) * 4) | 32'(lane);
        end
        return x;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive_idle(d);
            hwdata[d] = 32'h0;
            for (int w = 0; w < 64; w++) begin
                known[d][w] = 1'b0;
                mdl[d][w] = 32'h0;
            end
        end
        hreset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", 32'(hreadyout[d]), 32'h1);
            check_eq("rst_resp", 32'(hresp[d]), 32'h0);
            check_eq("rst_rdata", hrdata[d], 32'h0);
        end
        hreset = 1'b0;

        // word write/read, byte lane merge, out of range, bad size/alignment
        q.push_back(mk(1, 3'd2, 32'h10, 32'hDEADBEEF));
        q.push_back(mk(0, 3'd2, 32'h10, 32'h0));
        q.push_back(mk(1, 3'd2, 32'h10, 32'h11223344));
        q.push_back(mk(1, 3'd0, 32'h11, 32'h0000AA00));
        q.push_back(mk(0, 3'd2, 32'h10, 32'h0));
        q.push_back(mk(1, 3'd2, 32'h00, 32'h0BADF00D));
        q.push_back(mk(1, 3'd2, 32'(MW * 4), 32'hFFFFFFFF));
        q.push_back(mk(0, 3'd2, 32'h00, 32'h0));
        q.push_back(mk(1, 3'd2, 32'h02, 32'h12121212));
        q.push_back(mk(1, 3'd3, 32'h00, 32'h34343434));
        q.push_back(mk(0, 3'd2, 32'h00, 32'h0));
        run_queue(0);
        check_eq("byte_merge", mdl[0][4], 32'h1122AA44);

        // zero-wait back-to-back write then read of the same word
        q.push_back(mk(1, 3'd2, 32'h20, 32'h00000055));
        q.push_back(mk(0, 3'd2, 32'h20, 32'h0));
        run_queue(1);

        // reset in the middle of a waited write
        q.push_back(mk(1, 3'd2, 32'h30, 32'hCAFEF00D));
        run_queue(0);
        @(negedge clk);
        drive(0, mk(1, 3'd2, 32'h30, 32'h0));
        @(negedge clk);
        check_eq("rst_mid_wait", 32'(hreadyout[0]), 32'h0);
        hwdata[0] = 32'h12345678;
        drive_idle(0);
        hreset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_ready", 32'(hreadyout[0]), 32'h1);
        check_eq("rst_mid_resp", 32'(hresp[0]), 32'h0);
        check_eq("rst_mid_rdata", hrdata[0], 32'h0);
        hreset = 1'b0;
        q.push_back(mk(0, 3'd2, 32'h30, 32'h0));
        run_queue(0);

        // randomized traffic on both wait-state configurations
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) q.push_back(mk(1, 3'd2, 32'(w * 4), $urandom));
            for (int i = 0; i < 200; i++) q.push_back(rand_xfer());
            run_queue(d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
